fv_info_rx_issuer: RTL and testbench

- Receiving end of the FV-info path: accepts FV-info records emitted by the FV-info memory controller (base address + length + PE tag) and buffers them in a small sync FIFO.
- Expands each record into a sequence of single-word FV memory read requests toward the FV fetch side, tagged with the requesting PE.
- Provides the backpressure signal the controller consumes, so records are never lost in normal operation.

---
 rtl/fv_info_rx_issuer.sv | 160 ++++++++++++++++
 tb/tb_fv_info_rx_issuer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fv_info_rx_issuer.sv
// FV-info receiver: buffers {pe, base, len} records and expands each into single-word FV read requests.
// Optional macro FV_INFO_RX_STATS_EN adds saturating record/word/stall counters.
module fv_info_rx_issuer #(
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int ADDR_W    = 7,
  parameter int LEN_W     = 4,
  parameter int PE_W      = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              info_valid,
  input  logic [PE_W-1:0]   info_pe_id,
  input  logic [ADDR_W-1:0] info_base,
  input  logic [LEN_W-1:0]  info_len,
  output logic              info_almost_full,
  output logic              fv_req_valid,
  input  logic              fv_req_ready,
  output logic [ADDR_W-1:0] fv_req_addr,
  output logic [PE_W-1:0]   fv_req_pe_id,
  output logic              fv_req_last,
  output logic              busy,
  output logic              overflow_err
`ifdef FV_INFO_RX_STATS_EN
  ,
  output logic [15:0]       stat_rec_cnt,
  output logic [15:0]       stat_word_cnt,
  output logic [15:0]       stat_stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = PE_W + ADDR_W + LEN_W;
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - AF_MARGIN);

  typedef enum logic {IDLE, ISSUE} state_t;

  logic [REC_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              af_q, ovf_q;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [PE_W-1:0]   pe_q, pe_d;

  logic              fifo_empty, fifo_full, pop, push, drop, rem_one;
  logic [PE_W-1:0]   head_pe;
  logic [ADDR_W-1:0] head_base;
  logic [LEN_W-1:0]  head_len;

  assign {head_pe, head_base, head_len} = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_LVL);
  assign rem_one    = (rem_q == LEN_W'(1));
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push       = info_valid & (~fifo_full | pop);
  assign drop       = info_valid & fifo_full & ~pop;
  assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    pe_d    = pe_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          addr_d  = head_base;
          rem_d   = head_len;
          pe_d    = head_pe;
          state_d = (head_len != '0) ? ISSUE : IDLE;
        end
      end
      ISSUE: begin
        if (fv_req_ready) begin
          if (!rem_one) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next record so consecutive records have no bubble.
            pop     = 1'b1;
            addr_d  = head_base;
            rem_d   = head_len;
            pe_d    = head_pe;
            state_d = (head_len != '0) ? ISSUE : IDLE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {info_pe_id, info_base, info_len};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      pe_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      af_q    <= (count_d >= AF_LVL);
      if (drop) ovf_q <= 1'b1;
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pe_q    <= pe_d;
    end
  end

  assign info_almost_full = af_q;
  assign overflow_err     = ovf_q;
  assign fv_req_valid     = (state_q == ISSUE);
  assign fv_req_addr      = addr_q;
  assign fv_req_pe_id     = pe_q;
  assign fv_req_last      = (state_q == ISSUE) & rem_one;
  assign busy             = ~fifo_empty | (state_q != IDLE);

`ifdef FV_INFO_RX_STATS_EN
  logic [15:0] rec_cnt_q, word_cnt_q, stall_cnt_q;
  logic        acc, stall;

  assign acc   = fv_req_valid & fv_req_ready;
  assign stall = fv_req_valid & ~fv_req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_cnt_q   <= '0;
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (acc && rem_one && rec_cnt_q != 16'hFFFF) rec_cnt_q   <= rec_cnt_q + 16'd1;
      if (acc && word_cnt_q != 16'hFFFF)           word_cnt_q  <= word_cnt_q + 16'd1;
      if (stall && stall_cnt_q != 16'hFFFF)        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stat_rec_cnt   = rec_cnt_q;
  assign stat_word_cnt  = word_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fv_info_rx_issuer.sv
// Directed self-checking bench for fv_info_rx_issuer (default DEPTH=8, AF_MARGIN=2).
module tb_fv_info_rx_issuer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       info_valid = 1'b0;
  logic [1:0] info_pe_id = '0;
  logic [6:0] info_base = '0;
  logic [3:0] info_len = '0;
  logic       info_almost_full;
  logic       fv_req_valid;
  logic       fv_req_ready = 1'b0;
  logic [6:0] fv_req_addr;
  logic [1:0] fv_req_pe_id;
  logic       fv_req_last;
  logic       busy;
  logic       overflow_err;
`ifdef FV_INFO_RX_STATS_EN
  logic [15:0] stat_rec_cnt, stat_word_cnt, stat_stall_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  fv_info_rx_issuer dut (
    .clk              (clk),
    .reset            (reset),
    .info_valid       (info_valid),
    .info_pe_id       (info_pe_id),
    .info_base        (info_base),
    .info_len         (info_len),
    .info_almost_full (info_almost_full),
    .fv_req_valid     (fv_req_valid),
    .fv_req_ready     (fv_req_ready),
    .fv_req_addr      (fv_req_addr),
    .fv_req_pe_id     (fv_req_pe_id),
    .fv_req_last      (fv_req_last),
    .busy             (busy),
    .overflow_err     (overflow_err)
`ifdef FV_INFO_RX_STATS_EN
    ,
    .stat_rec_cnt     (stat_rec_cnt),
    .stat_word_cnt    (stat_word_cnt),
    .stat_stall_cnt   (stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record is sampled at the next rising edge; returns 1 time unit after that edge.
  task automatic push(input logic [1:0] pe, input logic [6:0] base, input logic [3:0] len);
    info_valid = 1'b1;
    info_pe_id = pe;
    info_base  = base;
    info_len   = len;
    step();
    info_valid = 1'b0;
  endtask

  task automatic expect_req(input string tag, input logic [6:0] addr, input logic [1:0] pe,
                            input logic last);
    check({tag, "_valid"}, 32'(fv_req_valid), 32'd1);
    check({tag, "_addr"},  32'(fv_req_addr),  32'(addr));
    check({tag, "_pe"},    32'(fv_req_pe_id), 32'(pe));
    check({tag, "_last"},  32'(fv_req_last),  32'(last));
  endtask

  task automatic expect_all_zero(input string tag);
    check({tag, "_valid"}, 32'(fv_req_valid),     32'd0);
    check({tag, "_addr"},  32'(fv_req_addr),      32'd0);
    check({tag, "_pe"},    32'(fv_req_pe_id),     32'd0);
    check({tag, "_last"},  32'(fv_req_last),      32'd0);
    check({tag, "_af"},    32'(info_almost_full), 32'd0);
    check({tag, "_busy"},  32'(busy),             32'd0);
    check({tag, "_ovf"},   32'(overflow_err),     32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    expect_all_zero("rst");
    reset = 1'b0;
    fv_req_ready = 1'b1;
    step();

    // Single record: two cycles from info_valid to the first request.
    push(2'd2, 7'd5, 4'd3);
    check("single_lat0_valid", 32'(fv_req_valid), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    step();
    expect_req("single_a5", 7'd5, 2'd2, 1'b0);
    step();
    expect_req("single_a6", 7'd6, 2'd2, 1'b0);
    step();
    expect_req("single_a7", 7'd7, 2'd2, 1'b1);
    step();
    check("single_done_valid", 32'(fv_req_valid), 32'd0);
    check("single_done_busy", 32'(busy), 32'd0);

    // Address wraps 127 -> 0.
    push(2'd1, 7'd126, 4'd4);
    step();
    expect_req("wrap_126", 7'd126, 2'd1, 1'b0);
    step();
    expect_req("wrap_127", 7'd127, 2'd1, 1'b0);
    step();
    expect_req("wrap_0", 7'd0, 2'd1, 1'b0);
    step();
    expect_req("wrap_1", 7'd1, 2'd1, 1'b1);
    step();
    check("wrap_done_valid", 32'(fv_req_valid), 32'd0);

    // Backpressure: three stalled cycles on the first word.
    fv_req_ready = 1'b0;
    push(2'd3, 7'd10, 4'd2);
    step();
    for (int i = 0; i < 3; i++) begin
      expect_req($sformatf("bp_hold%0d", i), 7'd10, 2'd3, 1'b0);
      step();
    end
    expect_req("bp_hold3", 7'd10, 2'd3, 1'b0);
`ifdef FV_INFO_RX_STATS_EN
    check("bp_stall_cnt", 32'(stat_stall_cnt), 32'd3);
    check("bp_word_cnt", 32'(stat_word_cnt), 32'd7);
`endif
    fv_req_ready = 1'b1;
    step();
    expect_req("bp_a11", 7'd11, 2'd3, 1'b1);
    step();
    check("bp_done_valid", 32'(fv_req_valid), 32'd0);
`ifdef FV_INFO_RX_STATS_EN
    check("bp_rec_cnt", 32'(stat_rec_cnt), 32'd3);
`endif

    // Back-to-back records: no bubble between them.
    push(2'd0, 7'd20, 4'd2);
    push(2'd1, 7'd40, 4'd1);
    expect_req("b2b_a20", 7'd20, 2'd0, 1'b0);
    step();
    expect_req("b2b_a21", 7'd21, 2'd0, 1'b1);
    step();
    expect_req("b2b_a40", 7'd40, 2'd1, 1'b1);
    step();
    check("b2b_done_valid", 32'(fv_req_valid), 32'd0);

    // Zero-length record between two single-word records.
    push(2'd2, 7'd50, 4'd1);
    push(2'd2, 7'd60, 4'd0);
    expect_req("zero_a50", 7'd50, 2'd2, 1'b1);
    push(2'd3, 7'd70, 4'd1);
    check("zero_gap_valid", 32'(fv_req_valid), 32'd0);
    step();
    expect_req("zero_a70", 7'd70, 2'd3, 1'b1);
    step();
    check("zero_done_valid", 32'(fv_req_valid), 32'd0);
    check("zero_done_busy", 32'(busy), 32'd0);

    // Fill: one record parks in ISSUE, then the FIFO fills behind it.
    fv_req_ready = 1'b0;
    push(2'd1, 7'd90, 4'd1);
    step();
    expect_req("fill_park", 7'd90, 2'd1, 1'b1);
    for (int i = 1; i <= 5; i++) push(2'd0, 7'(i), 4'd1);
    check("fill5_af", 32'(info_almost_full), 32'd0);
    push(2'd0, 7'd6, 4'd1);
    check("fill6_af", 32'(info_almost_full), 32'd1);
    push(2'd0, 7'd7, 4'd1);
    push(2'd0, 7'd8, 4'd1);
    check("fill8_ovf", 32'(overflow_err), 32'd0);
    push(2'd0, 7'd9, 4'd1);
    check("fill9_ovf", 32'(overflow_err), 32'd1);
    step();
    check("fill_ovf_sticky", 32'(overflow_err), 32'd1);
    check("fill_busy", 32'(busy), 32'd1);
    expect_req("fill_held", 7'd90, 2'd1, 1'b1);

    // Reset mid-record clears everything.
    reset = 1'b1;
    #1;
    expect_all_zero("rst2");
`ifdef FV_INFO_RX_STATS_EN
    check("rst2_stall_cnt", 32'(stat_stall_cnt), 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(fv_req_valid), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
